// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default and the
// command-master state enum.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns one valid/ready command (read or write) into a
// single AXI4-Lite transaction and hands the result back on a valid/ready
// response stream. One transaction outstanding at a time; every output is a
// register, so no AXI input reaches an AXI output combinationally.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int ERR_CNT_WIDTH      = 8
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  // command stream
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response stream
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  // status
  output logic                              busy,
  output logic [ERR_CNT_WIDTH-1:0]          err_count,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  state_t                          state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]               wstrb_q;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(
    input logic [ERR_CNT_WIDTH-1:0] v
  );
    if (&v) return v;
    return v + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Payloads come straight from the command latches, so they hold still
  // for as long as the matching VALID is high.
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;

  // Transaction sequencer with registered handshake, response and status outputs.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      err_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes up one cycle after reset release, then stays up
          // until a command is taken.
          if (cmd_ready && cmd_valid) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_write) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_AW_W;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        WR_AW_W: begin
          // AW and W retire independently; leave once neither is pending.
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
              (!M_AXI_WVALID  || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_B;
          end
        end

        WR_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= M_AXI_BRESP;
            if (M_AXI_BRESP != RESP_OKAY) err_count <= sat_inc(err_count);
            state        <= RSP;
          end
        end

        RD_AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_R;
          end
        end

        RD_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            if (M_AXI_RRESP != RESP_OKAY) err_count <= sat_inc(err_count);
            state        <= RSP;
          end
        end

        RSP: begin
          // Response fields are left untouched so they stay stable until consumed.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a behavioural AXI4-Lite slave with tunable
// ready delays, a queue-based response model and one per-cycle compare process.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [7:0]  err_count;
  logic [3:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4), .ERR_CNT_WIDTH(8)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .err_count(err_count),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
    .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // ---------------- response model ----------------
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [7:0]  errc;
  } exp_t;

  exp_t        expq[$];
  exp_t        cmp_e;
  logic [31:0] mdl_mem[4];
  int          mdl_err = 0;
  logic [1:0]  err_resp = 2'b00;

  task automatic model_push(input logic wr, input logic [3:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    e.wr   = wr;
    e.resp = err_resp;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) mdl_mem[addr[3:2]][8*b +: 8] = wd[8*b +: 8];
      e.rdata = 32'h0;
    end else begin
      e.rdata = mdl_mem[addr[3:2]];
    end
    if (err_resp != 2'b00 && mdl_err < 255) mdl_err++;
    e.errc = mdl_err[7:0];
    expq.push_back(e);
  endtask

  // ---------------- behavioural slave ----------------
  int          aw_d = 1, w_d = 1, ar_d = 1;
  bit          ar_stall = 1'b0;
  logic [31:0] s_mem[4];
  int          aw_c = 0, w_c = 0, ar_c = 0;
  bit          aw_got = 0, w_got = 0, ar_pend = 0;
  bit          s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
  logic [3:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int          b_hs_cnt = 0, b_hs_cyc = 0;
  bit          w_first_seen = 0;

  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RRESP = 0; RDATA = 0;
    for (int i = 0; i < 4; i++) s_mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      s_aw_hs = AWVALID && AWREADY;
      s_w_hs  = WVALID && WREADY;
      s_b_hs  = BVALID && BREADY;
      s_ar_hs = ARVALID && ARREADY;
      s_r_hs  = RVALID && RREADY;
      if (AWVALID && !s_aw_hs) aw_c++;
      if (WVALID && !s_w_hs) w_c++;
      if (ARVALID && !s_ar_hs) ar_c++;
      if (s_aw_hs) begin s_awaddr = AWADDR; aw_got = 1; aw_c = 0; end
      if (s_w_hs) begin s_wdata = WDATA; s_wstrb = WSTRB; w_got = 1; w_c = 0; end
      if (s_ar_hs) begin s_araddr = ARADDR; ar_pend = 1; ar_c = 0; end
      if (s_b_hs) begin b_hs_cnt++; b_hs_cyc = cyc; end
      if (AWVALID && !WVALID) w_first_seen = 1;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_c = 0; w_c = 0; ar_c = 0; aw_got = 0; w_got = 0; ar_pend = 0;
      end else begin
        if (s_b_hs) BVALID = 0;
        if (s_r_hs) RVALID = 0;
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) s_mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
          aw_got = 0; w_got = 0;
          BVALID = 1; BRESP = err_resp;
        end
        if (ar_pend) begin
          RVALID = 1; RDATA = s_mem[s_araddr[3:2]]; RRESP = err_resp; ar_pend = 0;
        end
        AWREADY = (aw_d == 0) ? 1'b1 : (AWVALID && aw_c >= aw_d);
        WREADY  = (w_d == 0)  ? 1'b1 : (WVALID && w_c >= w_d);
        ARREADY = !ar_stall && ((ar_d == 0) ? 1'b1 : (ARVALID && ar_c >= ar_d));
      end
    end
  end

  // ---------------- compare process ----------------
  bit          prev_v = 0, prev_r = 0, prev_w = 0;
  logic [31:0] prev_d = 0;
  logic [1:0]  prev_resp = 0;

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("rsp_hold_valid", rsp_valid, 1);
        chk("rsp_hold_fields", {rsp_write, rsp_resp, rsp_rdata}, {prev_w, prev_resp, prev_d});
      end
      if (busy) chk("cmd_ready_while_busy", cmd_ready, 0);
      if (AWVALID) chk("awprot", AWPROT, 0);
      if (ARVALID) chk("arprot", ARPROT, 0);
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected: response with empty model queue (t=%0t)", $time);
        end else begin
          cmp_e = expq.pop_front();
          chk("rsp_write", rsp_write, cmp_e.wr);
          chk("rsp_rdata", rsp_rdata, cmp_e.rdata);
          chk("rsp_resp", rsp_resp, cmp_e.resp);
          chk("err_count", err_count, cmp_e.errc);
        end
      end
      prev_v = rsp_valid; prev_r = rsp_ready; prev_w = rsp_write;
      prev_d = rsp_rdata; prev_resp = rsp_resp;
    end
  end

  // ---------------- driver ----------------
  int last_acc = 0;

  task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output int lat,
                        output logic [31:0] rd, output logic [1:0] rr);
    int acc;
    bit ok;
    lat = -1; rd = 32'hx; rr = 2'bx;
    model_push(wr, addr, wd, ws);
    @(negedge clk);
    rsp_ready = 1; cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wd; cmd_wstrb = ws;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin timeout("cmd_accept"); cmd_valid = 0; return; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    acc = cyc;
    last_acc = acc;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (rsp_valid) begin
        ok = 1; lat = cyc - acc + 1; rd = rsp_rdata; rr = rsp_resp; break;
      end
      @(negedge clk);
    end
    if (!ok) begin timeout("rsp_valid"); return; end
    @(posedge clk);
  endtask

  int          lat;
  logic [31:0] rd;
  logic [1:0]  rr;
  int          bcnt0;
  bit          ok;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) mdl_mem[i] = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_addr", AWADDR, 0);
    rst_n = 1;
    #1 chk("rst_release_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // UART-like slave: ready one cycle after valid
    aw_d = 1; w_d = 1; ar_d = 1;
    do_cmd(1, 4'h4, 32'h0000_01B2, 4'hF, lat, rd, rr);
    chk("uart_wr_lat", lat, 4);
    chk("uart_wr_rdata", rd, 32'h0);
    chk("uart_wr_resp", rr, 2'b00);
    do_cmd(0, 4'h4, 32'h0, 4'h0, lat, rd, rr);
    chk("uart_rd_lat", lat, 4);
    chk("uart_rd_rdata", rd, 32'h0000_01B2);
    chk("uart_rd_resp", rr, 2'b00);
    do_cmd(1, 4'hC, 32'hAABB_CCDD, 4'h2, lat, rd, rr);
    do_cmd(0, 4'hC, 32'h0, 4'h0, lat, rd, rr);
    chk("strobe_rd_rdata", rd, 32'h0000_CC00);

    // zero-wait slave: AWREADY and WREADY together
    aw_d = 0; w_d = 0; ar_d = 0;
    do_cmd(1, 4'h0, 32'h1234_5678, 4'hF, lat, rd, rr);
    chk("zw_wr_lat", lat, 3);
    do_cmd(0, 4'h0, 32'h0, 4'h0, lat, rd, rr);
    chk("zw_rd_lat", lat, 3);
    chk("zw_rd_rdata", rd, 32'h1234_5678);

    // WREADY three cycles ahead of AWREADY
    aw_d = 4; w_d = 1; ar_d = 1;
    w_first_seen = 0;
    bcnt0 = b_hs_cnt;
    do_cmd(1, 4'h8, 32'h0BAD_F00D, 4'hF, lat, rd, rr);
    chk("skew_w_first", w_first_seen, 1);
    chk("skew_b_count", b_hs_cnt - bcnt0, 1);
    chk("skew_lat", lat, 7);
    chk("skew_b_to_rsp", lat - (b_hs_cyc - last_acc + 1), 1);

    // SLVERR reads: saturating counter
    aw_d = 0; w_d = 0; ar_d = 0;
    err_resp = 2'b10;
    for (int i = 0; i < 300; i++) do_cmd(0, 4'h8, 32'h0, 4'h0, lat, rd, rr);
    chk("err_last_resp", rr, 2'b10);
    chk("err_saturated", err_count, 8'd255);
    err_resp = 2'b00;

    // response backpressure with a second command waiting
    model_push(0, 4'h4, 32'h0, 4'h0);
    model_push(0, 4'h0, 32'h0, 4'h0);
    @(negedge clk);
    rsp_ready = 0; cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h4;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) timeout("bp_accept");
    @(posedge clk);
    @(negedge clk);
    cmd_addr = 4'h0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) timeout("bp_rsp_valid");
    for (int i = 0; i < 10; i++) begin
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_cmd_ready", cmd_ready, 1);
    chk("bp_idle_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_accepted", busy, 1);
    cmd_valid = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) timeout("bp_second_rsp");
    @(posedge clk);

    // reset while AR is stalled
    ar_stall = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) timeout("rstmid_accept");
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    chk("rstmid_arvalid_before", ARVALID, 1);
    chk("rstmid_busy_before", busy, 1);
    rst_n = 0;
    mdl_err = 0;
    #1;
    chk("rstmid_arvalid", ARVALID, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_cmd_ready", cmd_ready, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_err_count", err_count, 0);
    ar_stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    do_cmd(0, 4'h0, 32'h0, 4'h0, lat, rd, rr);
    chk("rstmid_read_rdata", rd, 32'h1234_5678);
    chk("rstmid_read_resp", rr, 2'b00);

    repeat (3) @(negedge clk);
    chk("model_queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
